// File: rtl/counter_seq_ctrl.sv
// Sequencer for a down-counter: programmable reload, one-shot or periodic mode,
// clock-enable prescaler, pause/stop control and a saturating terminal-count tally.
module counter_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int DIV_W  = 4,
  parameter int TCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_load,
  input  logic              cfg_periodic,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              tc,
  output logic [TCNT_W-1:0] tc_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   reload, reload_nxt, count_nxt;
  logic               periodic, periodic_nxt;
  logic [DIV_W-1:0]   div, div_nxt, presc, presc_nxt;
  logic               tc_nxt;
  logic [TCNT_W-1:0]  tc_cnt_nxt;
  logic               accept;
  logic               step;

  assign cfg_ready = (state == IDLE) || (state == DONE);
  assign accept    = cfg_valid && cfg_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '1;
      reload   <= '1;
      periodic <= 1'b0;
      div      <= '0;
      presc    <= '0;
      tc       <= 1'b0;
      tc_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      count    <= count_nxt;
      reload   <= reload_nxt;
      periodic <= periodic_nxt;
      div      <= div_nxt;
      presc    <= presc_nxt;
      tc       <= tc_nxt;
      tc_cnt   <= tc_cnt_nxt;
      busy     <= (state_nxt == RUN) || (state_nxt == HOLD);
      done     <= (state_nxt == DONE);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    count_nxt    = count;
    reload_nxt   = reload;
    periodic_nxt = periodic;
    div_nxt      = div;
    presc_nxt    = presc;
    tc_nxt       = 1'b0;
    tc_cnt_nxt   = tc_cnt;
    step         = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          reload_nxt   = cfg_load;
          periodic_nxt = cfg_periodic;
          div_nxt      = cfg_div;
          count_nxt    = cfg_load;
          tc_cnt_nxt   = '0;
          state_nxt    = IDLE;
        end
        if (start) begin
          state_nxt = RUN;
          count_nxt = accept ? cfg_load : reload;
          presc_nxt = '0;
        end
      end
      RUN, HOLD: begin
        if (stop) begin
          state_nxt = IDLE;
          count_nxt = reload;
          presc_nxt = '0;
        end else if (pause) begin
          state_nxt = HOLD;
        end else if (state == HOLD) begin
          state_nxt = RUN;
        end else if (presc == div) begin
          presc_nxt = '0;
          step      = 1'b1;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
    endcase

    // Terminal step: count already at zero when the step arrives.
    if (step) begin
      if (count != '0) begin
        count_nxt = count - 1'b1;
      end else begin
        tc_nxt = 1'b1;
        if (tc_cnt != '1) tc_cnt_nxt = tc_cnt + 1'b1;
        if (periodic) count_nxt = reload;
        else          state_nxt = DONE;
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: behavioural model compared every
// negedge, directed scenarios with literal expectations, then random stimulus.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_load = '0;
  logic       cfg_periodic = 1'b0;
  logic [3:0] cfg_div = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] count;
  logic       busy, done, tc;
  logic [7:0] tc_cnt;

  int errors = 0;
  int checks = 0;

  counter_seq_ctrl #(.WIDTH(4), .DIV_W(4), .TCNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_load(cfg_load), .cfg_periodic(cfg_periodic), .cfg_div(cfg_div),
    .start(start), .stop(stop), .pause(pause), .count(count), .busy(busy),
    .done(done), .tc(tc), .tc_cnt(tc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a timer that is either active (running or paused) or
  // not, plus a sticky finished flag; steps happen every (div+1) running clks.
  bit m_valid = 0;
  bit m_active, m_paused, m_finished, m_periodic, m_tc;
  int m_count, m_reload, m_div, m_ticks, m_tcc;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_active = 0; m_paused = 0; m_finished = 0;
      m_count = 15; m_reload = 15; m_periodic = 0; m_div = 0;
      m_ticks = 0; m_tc = 0; m_tcc = 0;
    end else if (m_valid) begin
      m_tc = 0;
      if (!m_active) begin
        if (cfg_valid) begin
          m_reload = cfg_load; m_periodic = cfg_periodic; m_div = cfg_div;
          m_count = cfg_load; m_tcc = 0; m_finished = 0;
        end
        if (start) begin
          m_active = 1; m_paused = 0; m_finished = 0;
          m_count = m_reload; m_ticks = 0;
        end
      end else if (stop) begin
        m_active = 0; m_paused = 0; m_count = m_reload; m_ticks = 0;
      end else if (pause) begin
        m_paused = 1;
      end else if (m_paused) begin
        m_paused = 0;
      end else if (m_ticks < m_div) begin
        m_ticks++;
      end else begin
        m_ticks = 0;
        if (m_count > 0) m_count--;
        else begin
          m_tc = 1;
          m_tcc = (m_tcc < 255) ? m_tcc + 1 : 255;
          if (m_periodic) m_count = m_reload;
          else begin m_active = 0; m_finished = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("count", count, m_count);
      check("busy", busy, m_active);
      check("done", done, m_finished);
      check("cfg_ready", cfg_ready, !m_active);
      check("tc", tc, m_tc);
      check("tc_cnt", tc_cnt, m_tcc);
    end
  end

  // Advance one rising edge; return just after the following falling edge.
  task automatic clk_edge();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) clk_edge();
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; start = 0; stop = 0; pause = 0;
  endtask

  initial begin
    // 1: reset
    edges(2);
    rst = 0;
    check("rst_count", count, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_tc", tc, 0);
    check("rst_tc_cnt", tc_cnt, 0);

    // 2: one-shot, load 3, div 0
    cfg_valid = 1; cfg_load = 3; cfg_div = 0; cfg_periodic = 0;
    clk_edge(); idle_inputs();
    start = 1; clk_edge(); start = 0;
    check("os_e0", count, 3);
    clk_edge(); check("os_e1", count, 2);
    clk_edge(); check("os_e2", count, 1);
    clk_edge(); check("os_e3", count, 0);
    check("os_e3_tc", tc, 0);
    clk_edge();
    check("os_e4_tc", tc, 1);
    check("os_e4_done", done, 1);
    check("os_e4_busy", busy, 0);
    clk_edge();
    check("os_e5_tc", tc, 0);
    check("os_e5_count", count, 0);

    // 3: periodic, load 2, div 1; cfg offered during RUN must be ignored
    cfg_valid = 1; cfg_load = 2; cfg_div = 1; cfg_periodic = 1;
    clk_edge(); idle_inputs();
    start = 1; clk_edge(); start = 0;
    edges(6);
    check("per_first_tc", tc, 1);
    check("per_ready_run", cfg_ready, 0);
    cfg_valid = 1; cfg_load = 7; cfg_div = 0; cfg_periodic = 0;
    edges(2); idle_inputs();
    edges(10);
    check("per_tc_cnt", tc_cnt, 3);
    check("per_tc", tc, 1);
    check("per_reload_kept", count, 2);
    stop = 1; clk_edge(); stop = 0;

    // 4: load 9, div 1, pause four clocks at count 6
    cfg_valid = 1; cfg_load = 9; cfg_div = 1; cfg_periodic = 0;
    clk_edge(); idle_inputs();
    start = 1; clk_edge(); start = 0;
    edges(6);
    check("hold_pre", count, 6);
    pause = 1;
    for (int i = 0; i < 4; i++) begin
      clk_edge();
      check("hold_count", count, 6);
      check("hold_busy", busy, 1);
    end
    pause = 0;
    edges(2); check("resume_phase", count, 6);
    clk_edge(); check("resume_step", count, 5);

    // 5: start while running ignored, stop aborts, then reload 0 saturation
    start = 1; clk_edge(); start = 0;
    check("start_ignored", count, 5);
    stop = 1; clk_edge(); stop = 0;
    check("stop_count", count, 9);
    check("stop_busy", busy, 0);
    check("stop_tc", tc, 0);
    cfg_valid = 1; cfg_load = 0; cfg_div = 0; cfg_periodic = 1; start = 1;
    clk_edge(); idle_inputs();
    check("zero_start", count, 0);
    edges(260);
    check("sat_tc_cnt", tc_cnt, 8'hFF);
    check("sat_tc", tc, 1);

    // 6: reset mid-RUN and mid-HOLD
    rst = 1; clk_edge(); rst = 0;
    check("rst_run_count", count, 4'hF);
    check("rst_run_busy", busy, 0);
    check("rst_run_tc_cnt", tc_cnt, 0);
    cfg_valid = 1; cfg_load = 9; cfg_div = 0; cfg_periodic = 1; start = 1;
    clk_edge(); idle_inputs();
    edges(3);
    pause = 1; edges(2);
    check("hold_before_rst", busy, 1);
    rst = 1; clk_edge(); rst = 0; pause = 0;
    check("rst_hold_count", count, 4'hF);
    check("rst_hold_busy", busy, 0);
    check("rst_hold_ready", cfg_ready, 1);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 499) == 0);
      cfg_valid    = ($urandom_range(0, 9) == 0);
      cfg_load     = 4'($urandom);
      cfg_periodic = 1'($urandom);
      cfg_div      = 4'($urandom_range(0, 2));
      start        = ($urandom_range(0, 7) == 0);
      stop         = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      clk_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
